// File: rtl/cdf_lut_gen_pkg.sv
// cdf_lut_gen_pkg: shared histogram-equalization sizes and LUT generator state encoding
package cdf_lut_gen_pkg;
    localparam int NUM_BINS  = 64;
    localparam int ADDR_W    = 6;
    localparam int CDF_W     = 16;
    localparam int OUT_W     = 8;
    localparam int PIX_COUNT = 4096;
    localparam int OUT_MAX   = (1 << OUT_W) - 1;
    localparam int NUM_W     = CDF_W + OUT_W;
    localparam int CNT_W     = 5;
    typedef enum logic [3:0] {
        S_IDLE, S_MIN_RD, S_MIN_CHK, S_BIN_RD, S_BIN_WAIT,
        S_DIV_SETUP, S_DIV_RUN, S_WRITE, S_DONE
    } state_t;
endpackage

// File: rtl/cdf_lut_gen_if.sv
// cdf_lut_gen_if: CDF scratch-read bus and LUT write bus
interface cdf_lut_gen_if;
    import cdf_lut_gen_pkg::*;
    logic              cdf_rd_en;
    logic [ADDR_W-1:0] cdf_rd_addr;
    logic [CDF_W-1:0]  cdf_rd_data;
    logic              lut_wr_en;
    logic [ADDR_W-1:0] lut_wr_addr;
    logic [OUT_W-1:0]  lut_wr_data;
    modport master (output cdf_rd_en, cdf_rd_addr, lut_wr_en, lut_wr_addr, lut_wr_data, input cdf_rd_data);
    modport slave  (input cdf_rd_en, cdf_rd_addr, lut_wr_en, lut_wr_addr, lut_wr_data, output cdf_rd_data);
endinterface

// File: rtl/cdf_lut_divider.sv
// cdf_lut_divider: serial restoring divider, first step taken on the start edge, NUM_W cycles start-to-valid
module cdf_lut_divider
    import cdf_lut_gen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_num,
    input  logic [CDF_W-1:0] i_den,
    output logic [NUM_W-1:0] o_quo,
    output logic             o_valid
);
    logic [CDF_W-1:0] r_rem, r_den, w_rem_in, w_den_in, w_rem_nxt;
    logic [NUM_W-1:0] r_quo, w_quo_in;
    logic [CNT_W-1:0] r_cnt;
    logic [CDF_W:0]   w_sh;
    logic             r_valid, w_ge;
    assign w_rem_in  = i_start ? '0 : r_rem;
    assign w_quo_in  = i_start ? i_num : r_quo;
    assign w_den_in  = i_start ? i_den : r_den;
    assign w_sh      = {w_rem_in, w_quo_in[NUM_W-1]};
    assign w_ge      = w_sh >= {1'b0, w_den_in};
    assign w_rem_nxt = w_ge ? CDF_W'(w_sh - {1'b0, w_den_in}) : w_sh[CDF_W-1:0];
    assign o_quo     = r_quo;
    assign o_valid   = r_valid;
    // one quotient bit per cycle; valid pulses with the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_den   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_start || r_cnt != '0) begin
                r_rem <= w_rem_nxt;
                r_den <= w_den_in;
                r_quo <= {w_quo_in[NUM_W-2:0], w_ge};
                r_cnt <= i_start ? CNT_W'(NUM_W - 1) : r_cnt - 1'b1;
            end
            r_valid <= !i_start && r_cnt == CNT_W'(1);
        end
    end
endmodule

// File: rtl/cdf_lut_gen.sv
// cdf_lut_gen: finds cdf_min then writes the 64-entry equalization LUT
module cdf_lut_gen
    import cdf_lut_gen_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_lut_start,
    output logic          o_lut_busy,
    output logic          o_lut_done,
    cdf_lut_gen_if.master bus
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt, w_rd_addr, w_wr_addr;
    logic [CDF_W-1:0]  r_cdf_min, w_min_nxt, r_cdf, w_cdf_nxt, w_diff, w_den;
    logic [NUM_W-1:0]  w_num, w_quo;
    logic [OUT_W-1:0]  w_wr_data;
    logic              w_div_start, w_div_valid, w_rd_en, w_wr_en, w_busy, w_done;
    assign w_diff      = (r_cdf < r_cdf_min) ? '0 : r_cdf - r_cdf_min;
    assign w_num       = (NUM_W'(w_diff) << OUT_W) - NUM_W'(w_diff);
    assign w_den       = CDF_W'(PIX_COUNT) - r_cdf_min;
    assign w_div_start = r_state == S_DIV_SETUP && w_den != '0;
    cdf_lut_divider u_div (
        .clk(clk), .reset(reset), .i_start(w_div_start), .i_num(w_num),
        .i_den(w_den), .o_quo(w_quo), .o_valid(w_div_valid)
    );
    // state, datapath and registered outputs; outputs reflect the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_cdf_min       <= '0;
            r_cdf           <= '0;
            bus.cdf_rd_en   <= 1'b0;
            bus.cdf_rd_addr <= '0;
            bus.lut_wr_en   <= 1'b0;
            bus.lut_wr_addr <= '0;
            bus.lut_wr_data <= '0;
            o_lut_busy      <= 1'b0;
            o_lut_done      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_cdf_min       <= w_min_nxt;
            r_cdf           <= w_cdf_nxt;
            bus.cdf_rd_en   <= w_rd_en;
            bus.cdf_rd_addr <= w_rd_addr;
            bus.lut_wr_en   <= w_wr_en;
            bus.lut_wr_addr <= w_wr_addr;
            bus.lut_wr_data <= w_wr_data;
            o_lut_busy      <= w_busy;
            o_lut_done      <= w_done;
        end
    end
    // next state, bin index, cdf_min and captured cdf[i]
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_min_nxt   = r_cdf_min;
        w_cdf_nxt   = r_cdf;
        case (r_state)
            S_IDLE: if (i_lut_start) begin
                w_state_nxt = S_MIN_RD;
                w_idx_nxt   = '0;
            end
            S_MIN_RD: w_state_nxt = S_MIN_CHK;
            S_MIN_CHK: begin
                if (bus.cdf_rd_data != '0 || r_idx == ADDR_W'(NUM_BINS - 1)) begin
                    w_min_nxt   = bus.cdf_rd_data;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_BIN_RD;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = S_MIN_RD;
                end
            end
            S_BIN_RD: w_state_nxt = S_BIN_WAIT;
            S_BIN_WAIT: begin
                w_cdf_nxt   = bus.cdf_rd_data;
                w_state_nxt = S_DIV_SETUP;
            end
            S_DIV_SETUP: w_state_nxt = (w_den == '0) ? S_WRITE : S_DIV_RUN;
            S_DIV_RUN: w_state_nxt = w_div_valid ? S_WRITE : S_DIV_RUN;
            S_WRITE: begin
                w_state_nxt = (r_idx == ADDR_W'(NUM_BINS - 1)) ? S_DONE : S_BIN_RD;
                w_idx_nxt   = (r_idx == ADDR_W'(NUM_BINS - 1)) ? r_idx : r_idx + 1'b1;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
    // output values for the state being entered; zero denominator bypasses the divider
    always_comb begin
        w_rd_en   = w_state_nxt == S_MIN_RD || w_state_nxt == S_BIN_RD;
        w_rd_addr = w_rd_en ? w_idx_nxt : '0;
        w_wr_en   = w_state_nxt == S_WRITE;
        w_wr_addr = w_wr_en ? r_idx : '0;
        w_wr_data = !w_wr_en ? '0
                  : (r_state == S_DIV_SETUP) ? ((w_diff == '0 && r_cdf != '0) ? OUT_W'(OUT_MAX) : '0)
                  : (|w_quo[NUM_W-1:OUT_W]) ? OUT_W'(OUT_MAX) : w_quo[OUT_W-1:0];
        w_busy    = w_state_nxt != S_IDLE && w_state_nxt != S_DONE;
        w_done    = w_state_nxt == S_DONE;
    end
endmodule

// File: doc/cdf_lut_gen.md
Name: cdf_lut_gen

Overview:
- Downstream of the CDF stage in the histogram-equalization pipeline. Starts when the CDF stage reports completion.
- Reads the 64-entry CDF from scratch memory and finds cdf_min, the first non-zero CDF entry.
- Computes each equalization mapping as lut[i] = ((cdf[i] - cdf_min) * 255) / (PIX_COUNT - cdf_min), floor division.
- Writes the 64-entry mapping LUT that the pixel-remap stage consumes.

Parameters:
- NUM_BINS, 64, number of histogram/CDF entries.
- ADDR_W, 6, address width; equals log2(NUM_BINS).
- CDF_W, 16, width of one CDF word; PIX_COUNT must be < 2^CDF_W.
- OUT_W, 8, LUT entry width; OUT_MAX = 2^OUT_W - 1 = 255.
- PIX_COUNT, 4096, pixels per image; equals the final CDF value.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- lut_start  in  1  one-cycle pulse, driven from the CDF stage's done signal.
- cdf_rd_en  out  1  scratch-memory read strobe.
- cdf_rd_addr  out  ADDR_W  CDF read address.
- cdf_rd_data  in  CDF_W  read data; valid exactly 1 cycle after cdf_rd_en.
- lut_wr_en  out  1  LUT write strobe.
- lut_wr_addr  out  ADDR_W  LUT write address.
- lut_wr_data  out  OUT_W  LUT write data.
- lut_busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
- lut_done  out  1  one-cycle pulse when all NUM_BINS entries have been written.

Behaviour:
- Reset: all outputs are registered and go to 0. Internal state: FSM=IDLE, bin index=0, cdf_min=0.
- Reset mid-operation: abandons the run immediately. No further writes; no done pulse.
- lut_start is sampled only in IDLE. Pulses in any other state are ignored.
- FSM states: IDLE, MIN_RD, MIN_CHK, BIN_RD, BIN_WAIT, DIV_SETUP, DIV_RUN, WRITE, DONE.
- IDLE -> MIN_RD on lut_start. Bin index is cleared.
- MIN_RD: issues a read at the current index. -> MIN_CHK.
- MIN_CHK, data non-zero: cdf_min=data, index=0, -> BIN_RD.
- MIN_CHK, data zero, index==NUM_BINS-1: cdf_min=0, index=0, -> BIN_RD. This is the empty-image case.
- MIN_CHK, data zero, otherwise: index+1, -> MIN_RD.
- BIN_RD: issues a read at the current index. -> BIN_WAIT.
- BIN_WAIT: captures cdf[i]. -> DIV_SETUP.
- DIV_SETUP: loads the divider.
  - diff = (cdf[i] < cdf_min) ? 0 : cdf[i] - cdf_min.
  - numerator = (diff << 8) - diff, width CDF_W+8.
  - denominator = PIX_COUNT - cdf_min, width CDF_W.
- Denominator == 0 (all pixels in one bin): the divider is skipped.
  - Result is OUT_MAX if diff==0 and cdf[i]!=0, else 0.
  - Net effect: bins at or after the occupied bin map to 255; bins before it map to 0.
  - -> WRITE.
- Otherwise -> DIV_RUN.
- DIV_RUN: restoring divider, one quotient bit per cycle, exactly CDF_W+8 cycles. -> WRITE.
- WRITE: lut_wr_en=1 for exactly one cycle, lut_wr_addr=i, lut_wr_data = low OUT_W bits of the quotient. The quotient is ≤ 255 by construction.
  - i==NUM_BINS-1: -> DONE.
  - Otherwise: i+1, -> BIN_RD.
- DONE: lut_done=1 for one cycle. -> IDLE.
- Per-bin latency: 4 + (CDF_W+8) cycles = 28 at defaults; 4 cycles on the denominator-zero path.
- Search latency: 2 cycles per examined bin.
- LUT writes are strictly in ascending address order, exactly NUM_BINS writes per run.
- cdf_rd_en and lut_wr_en are never high in the same cycle.

Decomposition:
- Shared histeq package:
  - NUM_BINS, ADDR_W, CDF_W, OUT_W, PIX_COUNT.
  - OUT_MAX.
  - State encoding constants for this FSM.
- One sub-module: cdf_lut_divider, a serial restoring divider.
  - Ports: clk, reset, start, num[CDF_W+8], den[CDF_W], quo[CDF_W+8], valid.
  - Fixed latency of CDF_W+8 cycles.

Test Plan:
- Uniform image, cdf[i]=64*(i+1).
  - Response: cdf_min=64; lut[0]=0, lut[31]=125, lut[63]=255.
  - Exactly 64 writes, in ascending address order.
  - lut_done 2+64*28 cycles after start is accepted, ±2.
- Single occupied bin: cdf[i]=0 for i<10, 4096 for i≥10.
  - Response: lut[0..9]=0, lut[10..63]=255.
  - The divider is never started.
- Empty image, all cdf=0 -> all 64 entries written as 0; search stops after 64 reads; lut_done asserted.
- Leading zeros then ramp: cdf[0..4]=0, cdf[5]=100, cdf[63]=4096.
  - Response: cdf_min=100; lut[5]=0; lut[63]=255.
  - An intermediate bin with cdf=2098 writes floor(1998*255/3996)=127.
- reset asserted mid-run during DIV_RUN of bin 20.
  - Response: all outputs 0 next cycle; no further writes; no lut_done.
  - A following lut_start completes a full, correct run.
- lut_start pulsed while lut_busy -> ignored; exactly one lut_done and exactly 64 writes.
